// File: rtl/traffic_conflict_monitor_if.sv
// Lamp/observation bundle between an intersection controller and its conflict monitor.
// master: the side that drives the lamps and the operator clear (controller or bench).
// slave:  the monitor, which reads the lamps and reports fault, code, flash and count.
interface traffic_conflict_monitor_if;
  logic       red1, yellow1, green1;
  logic       red2, yellow2, green2;
  logic       red3, yellow3, green3;
  logic       turn;
  logic       orange;
  logic       white;
  logic       fault_clr;
  logic       fault;
  logic [3:0] fault_code;
  logic       flash;
  logic [7:0] fault_count;

  modport master (
    output red1, yellow1, green1, red2, yellow2, green2, red3, yellow3, green3,
    output turn, orange, white, fault_clr,
    input  fault, fault_code, flash, fault_count
  );

  modport slave (
    input  red1, yellow1, green1, red2, yellow2, green2, red3, yellow3, green3,
    input  turn, orange, white, fault_clr,
    output fault, fault_code, flash, fault_count
  );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Independent safety monitor for intersection signal lamps. Latches the first static
// (filtered) or transition (unfiltered) violation as a fault code and drives a flash
// square wave for the failsafe lamp driver.
// Optional: define FAULT_COUNT_EN to build the saturating fault-entry counter.
module traffic_conflict_monitor #(
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned FILTER     = 2,
  parameter int unsigned FLASH_DIV  = 4
) (
  input logic                        clock,
  input logic                        reset,
  traffic_conflict_monitor_if.slave  bus
);

  localparam int unsigned FiltW = $clog2(FILTER + 1);
  localparam int unsigned YelW  = $clog2(MIN_YELLOW + 1);
  localparam int unsigned DivW  = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  localparam logic [FiltW-1:0] FiltMax  = FiltW'(FILTER);
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER - 1);
  localparam logic [YelW-1:0]  YelMax   = YelW'(MIN_YELLOW);
  localparam logic [DivW-1:0]  DivLast  = DivW'(FLASH_DIV - 1);

  localparam logic [1:0] StArm     = 2'd0;
  localparam logic [1:0] StMonitor = 2'd1;
  localparam logic [1:0] StFault   = 2'd2;

  // Bit i is head i+1.
  logic [2:0] red, yel, grn;
  assign red = {bus.red3, bus.red2, bus.red1};
  assign yel = {bus.yellow3, bus.yellow2, bus.yellow1};
  assign grn = {bus.green3, bus.green2, bus.green1};

  logic [1:0]       state_q, state_d;
  logic [3:0]       code_q, code_d;
  logic             flash_q, flash_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [FiltW-1:0] filt_q, filt_d;
  logic [2:0]       prev_r_q, prev_y_q, prev_g_q;
  logic [YelW-1:0]  ycnt_q [3];
  logic [YelW-1:0]  ycnt_d [3];

  logic [2:0] head_bad, short_y, bad_seq;
  logic       c4, c5, c6, static_any;
  logic [3:0] static_code, qual_code;

  // Static rule evaluation and lowest-code selection.
  always_comb begin
    head_bad = '0;
    for (int i = 0; i < 3; i++) begin
      head_bad[i] = !((red[i] ^ yel[i] ^ grn[i]) && !(red[i] && yel[i] && grn[i]));
    end
    c4 = !red[1] && (!red[0] || !red[2]);
    c5 = (bus.white && !(&red)) || (bus.white == bus.orange);
    c6 = bus.turn && !(grn[2] && red[0] && red[1]);
    static_any = (|head_bad) || c4 || c5 || c6;
    if (head_bad[0])      static_code = 4'd1;
    else if (head_bad[1]) static_code = 4'd2;
    else if (head_bad[2]) static_code = 4'd3;
    else if (c4)          static_code = 4'd4;
    else if (c5)          static_code = 4'd5;
    else if (c6)          static_code = 4'd6;
    else                  static_code = 4'd0;
  end

  // Transition rules against last cycle's lamps, plus per-head yellow dwell counters.
  always_comb begin
    short_y = '0;
    bad_seq = '0;
    for (int i = 0; i < 3; i++) begin
      short_y[i] = prev_y_q[i] && !yel[i] && red[i] && (ycnt_q[i] < YelMax);
      bad_seq[i] = (prev_g_q[i] && !grn[i] && red[i]) ||
                   (prev_y_q[i] && !yel[i] && grn[i]) ||
                   (prev_r_q[i] && !red[i] && yel[i]);
      if (!yel[i])                ycnt_d[i] = '0;
      else if (ycnt_q[i] == YelMax) ycnt_d[i] = YelMax;
      else                        ycnt_d[i] = ycnt_q[i] + 1'b1;
    end
  end

  // Pick the winning qualified code; a static rule qualifies once it has persisted FILTER cycles.
  always_comb begin
    qual_code = 4'd0;
    if (static_any && (filt_q >= FiltLast)) begin
      qual_code = static_code;
    end else if (state_q == StMonitor && (|short_y)) begin
      qual_code = 4'd7;
    end else if (state_q == StMonitor && (|bad_seq)) begin
      qual_code = 4'd8;
    end
  end

  // Monitor FSM, filter counter and flash divider.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    flash_d = flash_q;
    div_d   = div_q;
    if (!static_any)            filt_d = '0;
    else if (filt_q == FiltMax) filt_d = FiltMax;
    else                        filt_d = filt_q + 1'b1;
    case (state_q)
      StArm, StMonitor: begin
        if (qual_code != 4'd0) begin
          state_d = StFault;
          code_d  = qual_code;
          flash_d = 1'b1;
          div_d   = '0;
        end else if (state_q == StArm && (&red) && !static_any) begin
          state_d = StMonitor;
        end
      end
      StFault: begin
        if (bus.fault_clr && !static_any) begin
          state_d = StArm;
          code_d  = 4'd0;
          flash_d = 1'b0;
          div_d   = '0;
          filt_d  = '0;
        end else if (div_q == DivLast) begin
          flash_d = !flash_q;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StArm;
    endcase
  end

  // State registers; previous-lamp copy resets to all red.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StArm;
      code_q   <= 4'd0;
      flash_q  <= 1'b0;
      div_q    <= '0;
      filt_q   <= '0;
      prev_r_q <= 3'b111;
      prev_y_q <= 3'b000;
      prev_g_q <= 3'b000;
      for (int i = 0; i < 3; i++) ycnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      flash_q  <= flash_d;
      div_q    <= div_d;
      filt_q   <= filt_d;
      prev_r_q <= red;
      prev_y_q <= yel;
      prev_g_q <= grn;
      for (int i = 0; i < 3; i++) ycnt_q[i] <= ycnt_d[i];
    end
  end

  assign bus.fault      = (state_q == StFault);
  assign bus.fault_code = code_q;
  assign bus.flash      = flash_q;

`ifdef FAULT_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Count FAULT entries, saturating; only reset clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != StFault && state_d == StFault && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  // Fault-entry counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign bus.fault_count = cnt_q;
`else
  assign bus.fault_count = 8'd0;
`endif

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor (MIN_YELLOW=3, FILTER=2, FLASH_DIV=4).
module tb_traffic_conflict_monitor;

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  traffic_conflict_monitor_if bus ();

  traffic_conflict_monitor #(
    .MIN_YELLOW (3),
    .FILTER     (2),
    .FLASH_DIV  (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = !clock;

`ifdef FAULT_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_lamps(input logic [2:0] h1, input logic [2:0] h2, input logic [2:0] h3,
                           input logic t, input logic o, input logic w);
    {bus.red1, bus.yellow1, bus.green1} = h1;
    {bus.red2, bus.yellow2, bus.green2} = h2;
    {bus.red3, bus.yellow3, bus.green3} = h3;
    bus.turn   = t;
    bus.orange = o;
    bus.white  = w;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Hold lamps for n cycles, expecting no fault at any point.
  task automatic run_clean(input string tag, input logic [2:0] h1, input logic [2:0] h2,
                           input logic [2:0] h3, input int n);
    set_lamps(h1, h2, h3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      step();
      check({tag, "_fault"}, 32'(bus.fault), 0);
      check({tag, "_code"}, 32'(bus.fault_code), 0);
      check({tag, "_flash"}, 32'(bus.flash), 0);
    end
  endtask

  task automatic clear_fault();
    set_lamps(R, R, R, 1'b0, 1'b1, 1'b0);
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
  endtask

  initial begin
    set_lamps(R, R, R, 1'b0, 1'b1, 1'b0);
    bus.fault_clr = 1'b0;
    #12;
    check("rst_fault", 32'(bus.fault), 0);
    check("rst_code", 32'(bus.fault_code), 0);
    check("rst_flash", 32'(bus.flash), 0);
    check("rst_count", 32'(bus.fault_count), 0);
    reset = 1'b0;

    // Legal cycle, yellow for exactly MIN_YELLOW.
    run_clean("t1_red", R, R, R, 2);
    run_clean("t1_grn", G, R, G, 5);
    run_clean("t1_yel", Y, R, Y, 3);
    run_clean("t1_red2", R, R, R, 1);
    run_clean("t1_x", R, G, R, 2);

    // One-cycle static glitch is filtered out.
    set_lamps(R, G, R, 1'b0, 1'b0, 1'b0);
    step();
    check("t2_glitch", 32'(bus.fault), 0);
    set_lamps(R, G, R, 1'b0, 1'b1, 1'b0);
    step();
    check("t2_glitch_gone", 32'(bus.fault), 0);
    // Cross-street conflict for two cycles.
    set_lamps(G, G, R, 1'b0, 1'b1, 1'b0);
    step();
    check("t2_cyc1", 32'(bus.fault), 0);
    step();
    check("t2_fault", 32'(bus.fault), 1);
    check("t2_code", 32'(bus.fault_code), 4);
    check("t2_flash0", 32'(bus.flash), 1);
    for (int k = 1; k < 16; k++) begin
      step();
      check("t2_flash", 32'(bus.flash), 32'(((k / 4) % 2) == 0));
    end
    check("t2_hold_code", 32'(bus.fault_code), 4);
    clear_fault();
    check("t2_clr", 32'(bus.fault), 0);
    check("t2_count", 32'(bus.fault_count), CountEn ? 1 : 0);
    run_clean("t2_arm", R, R, R, 1);

    // Short yellow.
    run_clean("t3_g", G, R, R, 1);
    run_clean("t3_y", Y, R, R, 2);
    set_lamps(R, R, R, 1'b0, 1'b1, 1'b0);
    step();
    check("t3_short_fault", 32'(bus.fault), 1);
    check("t3_short_code", 32'(bus.fault_code), 7);
    clear_fault();
    run_clean("t3_arm", R, R, R, 1);
    // Green straight to red.
    run_clean("t3_g2", G, R, R, 1);
    set_lamps(R, R, R, 1'b0, 1'b1, 1'b0);
    step();
    check("t3_seq_code", 32'(bus.fault_code), 8);
    clear_fault();
    run_clean("t3_arm2", R, R, R, 1);

    // Walk against traffic; clear refused while present.
    set_lamps(R, R, G, 1'b0, 1'b0, 1'b1);
    step();
    check("t4_cyc1", 32'(bus.fault), 0);
    step();
    check("t4_code", 32'(bus.fault_code), 5);
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    check("t4_clr_refused", 32'(bus.fault), 1);
    check("t4_clr_refused_code", 32'(bus.fault_code), 5);
    clear_fault();
    check("t4_clr_fault", 32'(bus.fault), 0);
    check("t4_clr_code", 32'(bus.fault_code), 0);
    check("t4_clr_flash", 32'(bus.flash), 0);
    // In ARM a G->R step is not checked.
    run_clean("t4_arm_g", G, R, R, 1);
    run_clean("t4_arm_r", R, R, R, 1);

    // Dark head 1 plus head 2 green: code 1 wins over code 4.
    set_lamps(OFF, G, R, 1'b0, 1'b1, 1'b0);
    step();
    check("t5_cyc1", 32'(bus.fault), 0);
    step();
    check("t5_code", 32'(bus.fault_code), 1);
    check("t5_count", 32'(bus.fault_count), CountEn ? 5 : 0);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_fault", 32'(bus.fault), 0);
    check("t5_rst_code", 32'(bus.fault_code), 0);
    check("t5_rst_flash", 32'(bus.flash), 0);
    check("t5_rst_count", 32'(bus.fault_count), 0);
    #2;
    reset = 1'b0;
    set_lamps(R, R, R, 1'b0, 1'b1, 1'b0);

    // Fault counter across three clear cycles (static faults taken from ARM).
    for (int i = 0; i < 3; i++) begin
      set_lamps(R, R, R, 1'b0, 1'b0, 1'b0);
      step();
      step();
      check("t6_code", 32'(bus.fault_code), 5);
      clear_fault();
      check("t6_clr", 32'(bus.fault), 0);
      check("t6_count", 32'(bus.fault_count), CountEn ? 32'(i + 1) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
- Independent safety monitor that reads the signal-lamp outputs driven by the intersection controller and flags illegal or unsafe lamp states.
- Checks two kinds of rule:
  - static rules: per-head lamp validity, cross-street conflicts, pedestrian conflicts, turn-arrow legality;
  - transition rules: minimum yellow time and legal G->Y->R sequencing.
- On a violation it latches a fault code and drives a flash output for the board's failsafe lamp driver.

Parameters:
- MIN_YELLOW, 3, minimum consecutive cycles a yellow lamp must be lit before its head goes red
- FILTER, 2, consecutive cycles a static violation must persist before it latches (>=1)
- FLASH_DIV, 4, half-period of the flash output in cycles (>=1)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- red1 yellow1 green1  in  1 each  head 1 lamps
- red2 yellow2 green2  in  1 each  head 2 (cross street) lamps
- red3 yellow3 green3  in  1 each  head 3 lamps
- turn  in  1  head 3 protected-turn arrow
- orange  in  1  pedestrian don't-walk lamp
- white  in  1  pedestrian walk lamp
- fault_clr  in  1  operator clear request
- fault  out  1  latched fault flag
- fault_code  out  4  first-fault code, 0 = none
- flash  out  1  failsafe flash square wave
- fault_count  out  8  fault-entry counter (see Optional Feature)

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset values: fault=0, fault_code=0, flash=0, fault_count=0, state=ARM, all counters 0, previous-lamp register = all red.
- Static conditions, evaluated every cycle. Codes:
  - 1/2/3: head 1/2/3 does not show exactly one of R/Y/G.
  - 4: head 2 not red while head 1 or head 3 is not red.
  - 5: white lit while any head is not red, or white==orange.
  - 6: turn lit without (green3 & red1 & red2).
- Filter: one counter shared across all static conditions. It increments while any static condition is true and clears to 0 when none is true. A static fault latches at the edge where the counter reaches FILTER, so fault is visible FILTER cycles after the condition first appears.
- Transition conditions compare the current lamps with a registered copy of the previous cycle's lamps. Codes:
  - 7: a head goes Y->R with its yellow counter < MIN_YELLOW.
  - 8: any of G->R, Y->G or R->Y on a head.
  - Transition faults are not filtered; they latch on the next edge, i.e. 1-cycle latency.
- Yellow counter, one per head:
  - counts consecutive cycles yellow is sampled lit; saturates at MIN_YELLOW; clears when yellow is off.
  - A yellow lasting exactly MIN_YELLOW cycles is legal.
- Priority: when several conditions qualify on the same edge, the lowest code wins.
- FSM:
  - ARM: static checks active; transition checks disabled. -> MONITOR on the first cycle all three heads show red with no static condition.
  - MONITOR: all checks active. -> FAULT on any qualifying condition.
  - FAULT: fault=1 and fault_code is held. Later violations are ignored (first fault is kept).
  - FAULT exit: fault_clr with no static condition true that cycle -> ARM, clearing fault, fault_code, flash and the filter counter.
  - fault_clr is ignored outside FAULT, and ignored in FAULT while a static condition is present.
- ARM -> FAULT: a static fault latched in ARM also goes to FAULT.
- Flash: 0 outside FAULT. On FAULT entry flash=1, then toggles every FLASH_DIV cycles via a divider counter that restarts on FAULT entry.
- Reset asserted mid-operation: all outputs and state return to reset values immediately, independent of clock.

Optional Feature:
- Macro FAULT_COUNT_EN.
- Defined:
  - fault_count increments by 1 on every entry into FAULT and saturates at 255.
  - Cleared only by reset; fault_clr does not clear it.
- Undefined: fault_count is tied to 0 and no counter logic is built.

Test Plan:
1. Reset, then drive all-red+orange 2 cyc, green1/green3/red2+orange 5 cyc, yellow1/yellow3/red2 3 cyc, all-red+orange, then red1/red3/green2+orange -> fault stays 0, fault_code 0, flash 0 throughout.
2. From MONITOR, drive green1=1 and green2=1 (red1=red2=0) for 1 cycle, then restore -> no fault. Drive it again for 2 cycles -> fault=1, fault_code=4, flash=1 for 4 cycles then 0 for 4 cycles, repeating.
3. green1 -> yellow1 for 2 cycles -> red1 (MIN_YELLOW=3) -> fault_code=7 one cycle after red1. Repeat with a direct green1 -> red1 -> fault_code=8.
4. white=1 with green3=1 for 2 cycles -> fault_code=5. Pulse fault_clr while still present -> fault stays 1. Remove the condition, pulse fault_clr -> next cycle fault=0, fault_code=0, flash=0, state ARM.
5. Head 1 all lamps off together with head 2 green for 2 cycles -> fault_code=1 (priority). Assert reset between clock edges while in FAULT -> fault, fault_code and flash read 0 before the next edge.
6. With FAULT_COUNT_EN defined: cause and clear 3 faults -> fault_count=3, unchanged by fault_clr. Without the macro -> fault_count=0.
